piso_tx_ctrl: RTL
=================

# piso_tx_ctrl

Serial transmit controller that owns a WIDTH-bit parallel-in/serial-out shift register and sequences it. It accepts parallel words over a valid/ready handshake, loads the register, and shifts the word out MSB-first, holding each bit for a programmable number of clocks. Frame and done strobes are generated for downstream logic. It sits between a word-producing block and a single-wire serial sink, replacing hand-driven load/shift control of the PISO datapath.

## Interface
- WIDTH, 4, data word width; legal range 2..16.
- DIV, 1, clocks per serial bit; legal range 1..256.
- clk  in  1  clock; all state updates on the rising edge.
- res  in  1  reset; synchronous, active-high.
- d  in  WIDTH  parallel word; sampled only on the accepting edge.
- valid  in  1  producer has a word on d.
- ready  out  1  controller accepts d on this edge if valid=1.
- o  out  1  serial data output, MSB first.
- frame  out  1  high for every cycle of a frame, including the parity bit when present.
- busy  out  1  high while the state is SHIFT or PAR.
- done  out  1  one-cycle pulse in the final cycle of each frame.

## Operation
- State machine has three states.
  - IDLE: no frame in progress.
  - SHIFT: data bits of the word are being sent.
  - PAR: the parity bit is being sent. This state exists only with PARITY_EN.
- Acceptance: a word is accepted on a rising edge where valid=1, ready=1 and res=0.
- ready is combinational and equals ~res & (IDLE | last_cycle).
  - last_cycle is the final clock of the final bit of the current frame.
- On acceptance:
  - Load d into the shift register.
  - Clear the bit counter and the divider counter.
  - Enter SHIFT.
  - Compute the parity accumulator from d (XOR reduction).
- In SHIFT:
  - o = shift register MSB.
  - The divider counts 0..DIV-1.
  - On divider wrap, shift left by one with a 0 fill and increment the bit counter.
  - After WIDTH bits, go to PAR if PARITY_EN is defined. Otherwise leave the frame.
- In PAR:
  - o = even-parity bit, the XOR of all WIDTH accepted data bits.
  - The bit is held for DIV cycles.
- Frame end:
  - If a word is accepted in last_cycle, start the new frame in the next cycle with no gap: SHIFT, bit 0.
  - Otherwise go to IDLE.
- In IDLE: o=0, frame=0, busy=0, done=0.
- A word presented while busy and not in last_cycle is not accepted. The producer holds it.
- Dropping valid before acceptance is legal. No state changes.
- Counters: the bit counter is width clog2(WIDTH+1) and the divider is width clog2(DIV). When DIV=1 the divider is constant 0, so every cycle is a wrap.

## Timing
- Reset: while res=1 at an edge, the next state is IDLE and all counters are cleared.
  - Outputs after that edge: o=0, frame=0, busy=0, done=0.
  - ready=0 while res=1.
- Reset mid-frame: the in-flight word is discarded. No done is issued. The block is in IDLE the cycle after.
- Latency: a word accepted at edge N has its MSB on o from cycle N+1.
  - Bit i (i=0 is the MSB) occupies cycles N+1+i·DIV through N+(i+1)·DIV.
- Frame length L = (WIDTH+P)·DIV cycles, where P=1 with PARITY_EN and P=0 without.
  - frame and busy are high for exactly L cycles.
  - done is high only in cycle N+L.
- Throughput: with valid held high, frames are contiguous. One word is transferred every L cycles.
- res has priority over acceptance in the same cycle.

## Configuration
- PARITY_EN: when defined, the PAR state is built and each frame has WIDTH+1 bits. The last bit is even parity over the data bits.
- When undefined, there is no PAR state and no parity logic, and each frame has WIDTH bits.

## Test plan
- Single word, WIDTH=4, DIV=1, no parity: accept 4'b1011 at edge N -> o=1,0,1,1 in cycles N+1..N+4; frame=1 for 4 cycles; done only at N+4; IDLE at N+5 with o=0.
- PARITY_EN, WIDTH=4, DIV=1: accept 4'b1011 -> o=1,0,1,1,1; frame=1 for 5 cycles. Accept 4'b1001 -> fifth bit is 0.
- DIV=3, no parity: accept 4'b1001 -> o=1 for 3 cycles, 0 for 6 cycles, 1 for 3 cycles; done at N+12.
- Back-to-back, DIV=1, no parity: valid held high with 4'b1100 then 4'b0011 -> ready high in IDLE and at N+4; o=1,1,0,0,0,0,1,1 over 8 contiguous frame cycles; done at N+4 and N+8.
- Busy rejection: valid=1 with 4'b0110 during cycles N+1..N+3 of a frame -> ready=0 and no load; the word is accepted at N+4 only.
- Reset mid-frame: res=1 at N+2 of a 4'b1111 frame -> from N+3, o=0, frame=0, busy=0, and no done pulse; a fresh 4'b0101 accepted after release shifts out correctly.

Source files
------------

// File: rtl/piso_tx_ctrl.sv
// piso_tx_ctrl: serial transmit controller for a WIDTH-bit PISO shift register.
// Accepts parallel words over valid/ready, shifts them out MSB-first with each
// bit held for DIV clocks, and generates frame/busy/done strobes.
// Optional feature macro: PARITY_EN appends an even-parity bit to each frame.
// Legal parameter ranges: WIDTH 2..16, DIV 1..256.

module piso_tx_ctrl #(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             res,
  input  logic [WIDTH-1:0] d,
  input  logic             valid,
  output logic             ready,
  output logic             o,
  output logic             frame,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  // Reject out-of-range configurations at elaboration time.
  generate
    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
      $error("piso_tx_ctrl: WIDTH must be in 2..16");
    end
    if (DIV < 1 || DIV > 256) begin : g_bad_div
      $error("piso_tx_ctrl: DIV must be in 1..256");
    end
  endgenerate

`ifdef PARITY_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_PAR   = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1
  } state_t;
`endif

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_n;
  logic [CW-1:0]    bit_cnt;
  logic [CW-1:0]    bit_cnt_n;
  logic [DW-1:0]    div_cnt;
  logic [DW-1:0]    div_cnt_n;
`ifdef PARITY_EN
  logic             par;
  logic             par_n;
`endif

  logic             o_n;
  logic             busy_n;
  logic             done_n;
  logic             div_wrap;
  logic             accept;

  // With DIV=1 the divider never leaves 0, so every cycle is a wrap.
  assign div_wrap = (div_cnt == DIV_LAST);

  // The registered done flag marks the final cycle of a frame, which is the
  // only in-frame cycle where a new word may be taken without a gap.
  assign ready  = ~res & ((state == S_IDLE) | done);
  assign accept = valid & ready;

  // frame and busy cover exactly the same cycles.
  assign frame = busy;

  // Next-state logic: advance divider/bit counters, then let an accepted word
  // override whatever the frame-end decision was.
  always_comb begin
    state_n   = state;
    sreg_n    = sreg;
    bit_cnt_n = bit_cnt;
    div_cnt_n = div_cnt;
`ifdef PARITY_EN
    par_n     = par;
`endif

    case (state)
      S_IDLE: begin
        state_n = S_IDLE;
      end

      S_SHIFT: begin
        if (div_wrap) begin
          div_cnt_n = '0;
          sreg_n    = {sreg[WIDTH-2:0], 1'b0};
          bit_cnt_n = bit_cnt + CW'(1);
          if (bit_cnt == BIT_LAST) begin
`ifdef PARITY_EN
            state_n = S_PAR;
`else
            state_n = S_IDLE;
`endif
          end
        end else begin
          div_cnt_n = div_cnt + DW'(1);
        end
      end

`ifdef PARITY_EN
      S_PAR: begin
        if (div_wrap) begin
          div_cnt_n = '0;
          state_n   = S_IDLE;
        end else begin
          div_cnt_n = div_cnt + DW'(1);
        end
      end
`endif

      default: begin
        state_n   = S_IDLE;
        bit_cnt_n = '0;
        div_cnt_n = '0;
      end
    endcase

    if (accept) begin
      state_n   = S_SHIFT;
      sreg_n    = d;
      bit_cnt_n = '0;
      div_cnt_n = '0;
`ifdef PARITY_EN
      par_n     = ^d;
`endif
    end
  end

  // Output decode from the next state so that o/busy/done come straight out
  // of flops and line up with the cycle the state describes.
  always_comb begin
    o_n    = 1'b0;
    busy_n = (state_n != S_IDLE);
    done_n = 1'b0;

    case (state_n)
      S_SHIFT: begin
        o_n = sreg_n[WIDTH-1];
`ifndef PARITY_EN
        done_n = (bit_cnt_n == BIT_LAST) && (div_cnt_n == DIV_LAST);
`endif
      end
`ifdef PARITY_EN
      S_PAR: begin
        o_n    = par_n;
        done_n = (div_cnt_n == DIV_LAST);
      end
`endif
      default: begin
        o_n    = 1'b0;
        done_n = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset discards any in-flight word.
  always_ff @(posedge clk) begin
    if (res) begin
      state   <= S_IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
`ifdef PARITY_EN
      par     <= 1'b0;
`endif
      o       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      sreg    <= sreg_n;
      bit_cnt <= bit_cnt_n;
      div_cnt <= div_cnt_n;
`ifdef PARITY_EN
      par     <= par_n;
`endif
      o       <= o_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

endmodule
